// File: rtl/controlador_permutacao.sv
// Draws LFSR words for an external permutation generator, retries rejected draws,
// and hands an accepted 4-slot permutation to the consumer one index at a time.
module controlador_permutacao #(
   parameter int          MAX_TENT = 8,
   parameter logic [15:0] SEMENTE  = 16'hACE1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic        abort,
   input  logic [7:0]  gen_perm,
   input  logic        gen_ready,
   input  logic        idx_ack,
   output logic [15:0] gen_entrada,
   output logic [1:0]  idx_out,
   output logic        idx_valid,
   output logic [1:0]  slot,
   output logic        busy,
   output logic        done,
   output logic        erro,
   output logic [3:0]  tentativas
);

   typedef enum logic [2:0] {
      IDLE, SORTEIA, ESPERA, AVALIA, EMITE, FIM, ERRO
   } estado_t;

   localparam logic [3:0] LIMITE = 4'(MAX_TENT);

   estado_t     state, state_next;
   logic [15:0] lfsr, lfsr_next;
   logic [15:0] entrada_next;
   logic [7:0]  perm, perm_next;
   logic [1:0]  slot_next;
   logic [3:0]  tentativas_next;
   logic [15:0] lfsr_avanco;
   logic [3:0]  tentativas_inc;

   assign lfsr_avanco    = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   assign tentativas_inc = tentativas + 4'd1;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         lfsr        <= SEMENTE;
         gen_entrada <= 16'h0000;
         perm        <= 8'h00;
         slot        <= 2'd0;
         tentativas  <= 4'd0;
      end else begin
         state       <= state_next;
         lfsr        <= lfsr_next;
         gen_entrada <= entrada_next;
         perm        <= perm_next;
         slot        <= slot_next;
         tentativas  <= tentativas_next;
      end
   end

   always_comb begin
      state_next      = state;
      lfsr_next       = lfsr;
      entrada_next    = gen_entrada;
      perm_next       = perm;
      slot_next       = slot;
      tentativas_next = tentativas;

      // abort wins over everything; SORTEIA is skipped so the LFSR keeps its value
      if (abort) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state_next      = SORTEIA;
                  tentativas_next = 4'd0;
               end
            end
            SORTEIA: begin
               entrada_next = lfsr;
               lfsr_next    = lfsr_avanco;
               state_next   = ESPERA;
            end
            ESPERA: begin
               state_next = AVALIA;
            end
            AVALIA: begin
               if (gen_ready) begin
                  perm_next  = gen_perm;
                  slot_next  = 2'd0;
                  state_next = EMITE;
               end else begin
                  if (tentativas < LIMITE)
                     tentativas_next = tentativas_inc;
                  if (tentativas_inc >= LIMITE)
                     state_next = ERRO;
                  else
                     state_next = SORTEIA;
               end
            end
            EMITE: begin
               if (idx_ack) begin
                  if (slot == 2'd3)
                     state_next = FIM;
                  else
                     slot_next = slot + 2'd1;
               end
            end
            FIM: begin
               state_next = IDLE;
            end
            ERRO: begin
               if (start) begin
                  tentativas_next = 4'd0;
                  state_next      = SORTEIA;
               end
            end
            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

   // slot 0 lives in the most significant pair of the latched permutation
   always_comb begin
      case (slot)
         2'd0:    idx_out = perm[7:6];
         2'd1:    idx_out = perm[5:4];
         2'd2:    idx_out = perm[3:2];
         default: idx_out = perm[1:0];
      endcase
   end

   assign idx_valid = (state == EMITE);
   assign busy      = (state != IDLE) && (state != ERRO);
   assign done      = (state == FIM);
   assign erro      = (state == ERRO);

endmodule

// File: tb/tb_controlador_permutacao.sv
// Scoreboard bench: a behavioural generator reacts to each new gen_entrada word and
// queues the expected indices, which are popped as the consumer accepts them.
module tb_controlador_permutacao;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [7:0]  gen_perm = 8'h00;
   logic        gen_ready = 1'b0;
   logic        idx_ack = 1'b0;
   logic [15:0] gen_entrada;
   logic [1:0]  idx_out;
   logic        idx_valid;
   logic [1:0]  slot;
   logic        busy;
   logic        done;
   logic        erro;
   logic [3:0]  tentativas;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] lfsr_m;
   logic [15:0] last_word;
   int          reject_left;
   logic [7:0]  perm_plan;
   logic [15:0] draws[$];
   logic [3:0]  exp_q[$];

   always #5 clock = ~clock;

   controlador_permutacao #(.MAX_TENT(8), .SEMENTE(16'hACE1)) dut (
      .clock(clock), .reset(reset), .start(start), .abort(abort),
      .gen_perm(gen_perm), .gen_ready(gen_ready), .idx_ack(idx_ack),
      .gen_entrada(gen_entrada), .idx_out(idx_out), .idx_valid(idx_valid),
      .slot(slot), .busy(busy), .done(done), .erro(erro), .tentativas(tentativas)
   );

   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
   endfunction

   // advance one clock, then let the generator model answer any freshly drawn word
   task automatic cycle();
      @(posedge clock);
      #1;
      if (gen_entrada != last_word && gen_entrada != 16'h0000) begin
         last_word = gen_entrada;
         draws.push_back(gen_entrada);
         if (reject_left > 0) begin
            gen_ready = 1'b0;
            gen_perm  = ~perm_plan;
            reject_left--;
         end else begin
            gen_ready = 1'b1;
            gen_perm  = perm_plan;
            for (int s = 0; s < 4; s++)
               exp_q.push_back({2'(s), perm_plan[7-2*s -: 2]});
         end
      end
   endtask

   task automatic apply_reset();
      reset = 1'b1; start = 1'b0; abort = 1'b0; idx_ack = 1'b0;
      gen_ready = 1'b0; gen_perm = 8'h00;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      lfsr_m = 16'hACE1; last_word = 16'h0000;
      draws.delete(); exp_q.delete();
   endtask

   task automatic test_reset();
      apply_reset();
      checks++;
      if (gen_entrada !== 16'h0000) begin
         errors++; $display("FAIL reset_gen_entrada got %h exp 0000", gen_entrada);
      end
      checks++;
      if ({idx_out, slot, idx_valid, busy, done, erro, tentativas} !== 14'h0) begin
         errors++;
         $display("FAIL reset_outputs got idx %0d slot %0d v %b b %b d %b e %b t %0d exp all 0",
                  idx_out, slot, idx_valid, busy, done, erro, tentativas);
      end
   endtask

   task automatic test_basic();
      int first_valid = -1, last_emit = -1, emitted = 0, done_cnt = 0, done_cyc = -1;
      logic [3:0] e;
      logic [15:0] w;
      reject_left = 0; perm_plan = 8'h1B; idx_ack = 1'b1;
      start = 1'b1; cycle(); start = 1'b0;
      for (int n = 2; n <= 30; n++) begin
         cycle();
         if (n == 2) begin
            checks++;
            if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b exp 1", busy); end
         end
         if (idx_valid) begin
            if (first_valid < 0) first_valid = n;
            last_emit = n; emitted++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL basic_idx unexpected slot %0d idx %0d", slot, idx_out);
            end else begin
               e = exp_q.pop_front();
               if ({slot, idx_out} !== e) begin
                  errors++;
                  $display("FAIL basic_idx got slot %0d idx %0d exp slot %0d idx %0d",
                           slot, idx_out, e[3:2], e[1:0]);
               end
            end
         end
         if (done) begin done_cnt++; done_cyc = n; end
      end
      checks++;
      if (first_valid != 4) begin errors++; $display("FAIL basic_latency got %0d exp 4", first_valid); end
      checks++;
      if (emitted != 4 || last_emit != first_valid + 3) begin
         errors++; $display("FAIL basic_emit_count got %0d/%0d exp 4/%0d", emitted, last_emit, first_valid + 3);
      end
      checks++;
      if (done_cnt != 1 || done_cyc != last_emit + 1) begin
         errors++; $display("FAIL basic_done got cnt %0d at %0d exp 1 at %0d", done_cnt, done_cyc, last_emit + 1);
      end
      checks++;
      if (draws.size() != 1) begin
         errors++; $display("FAIL basic_draw_count got %0d exp 1", draws.size());
      end else begin
         w = draws.pop_front();
         if (w !== 16'hACE1) begin errors++; $display("FAIL basic_first_word got %h exp ace1", w); end
         lfsr_m = lfsr_step(lfsr_m);
      end
      checks++;
      if (tentativas !== 4'd0) begin errors++; $display("FAIL basic_tentativas got %0d exp 0", tentativas); end
   endtask

   task automatic test_retry();
      int emitted = 0, done_cnt = 0;
      logic [3:0] e;
      logic [15:0] w;
      reject_left = 2; perm_plan = 8'hE4; idx_ack = 1'b1;
      start = 1'b1; cycle(); start = 1'b0;
      for (int n = 0; n < 50; n++) begin
         cycle();
         if (idx_valid) begin
            emitted++; checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL retry_idx unexpected slot %0d idx %0d", slot, idx_out);
            end else begin
               e = exp_q.pop_front();
               if ({slot, idx_out} !== e) begin
                  errors++;
                  $display("FAIL retry_idx got slot %0d idx %0d exp slot %0d idx %0d",
                           slot, idx_out, e[3:2], e[1:0]);
               end
            end
         end
         if (done) done_cnt++;
      end
      checks++;
      if (draws.size() != 3) begin errors++; $display("FAIL retry_draw_count got %0d exp 3", draws.size()); end
      while (draws.size() > 0) begin
         w = draws.pop_front(); checks++;
         if (w !== lfsr_m) begin errors++; $display("FAIL retry_word got %h exp %h", w, lfsr_m); end
         lfsr_m = lfsr_step(lfsr_m);
      end
      checks++;
      if (tentativas !== 4'd2) begin errors++; $display("FAIL retry_tentativas got %0d exp 2", tentativas); end
      checks++;
      if (emitted != 4 || done_cnt != 1) begin
         errors++; $display("FAIL retry_emit got %0d done %0d exp 4 done 1", emitted, done_cnt);
      end
   endtask

   task automatic test_error();
      int done_cnt = 0;
      logic [3:0] e;
      logic [15:0] w;
      reject_left = 1000; perm_plan = 8'h1B; idx_ack = 1'b1;
      start = 1'b1; cycle(); start = 1'b0;
      for (int n = 0; n < 60; n++) begin
         cycle();
         if (erro) break;
      end
      checks++;
      if (erro !== 1'b1 || tentativas !== 4'd8) begin
         errors++; $display("FAIL error_flag got erro %b t %0d exp erro 1 t 8", erro, tentativas);
      end
      checks++;
      if (busy !== 1'b0 || idx_valid !== 1'b0) begin
         errors++; $display("FAIL error_idle_outputs got busy %b valid %b exp 0 0", busy, idx_valid);
      end
      checks++;
      if (draws.size() != 8) begin errors++; $display("FAIL error_draw_count got %0d exp 8", draws.size()); end
      while (draws.size() > 0) begin
         w = draws.pop_front(); checks++;
         if (w !== lfsr_m) begin errors++; $display("FAIL error_word got %h exp %h", w, lfsr_m); end
         lfsr_m = lfsr_step(lfsr_m);
      end
      repeat (3) cycle();
      checks++;
      if (erro !== 1'b1 || tentativas !== 4'd8) begin
         errors++; $display("FAIL error_hold got erro %b t %0d exp erro 1 t 8", erro, tentativas);
      end
      reject_left = 0; perm_plan = 8'hB1;
      start = 1'b1; cycle(); start = 1'b0;
      checks++;
      if (erro !== 1'b0 || tentativas !== 4'd0 || busy !== 1'b1) begin
         errors++; $display("FAIL error_restart got erro %b t %0d busy %b exp 0 0 1", erro, tentativas, busy);
      end
      for (int n = 0; n < 30; n++) begin
         cycle();
         if (idx_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL error_resume_idx unexpected slot %0d idx %0d", slot, idx_out);
            end else begin
               e = exp_q.pop_front();
               if ({slot, idx_out} !== e) begin
                  errors++;
                  $display("FAIL error_resume_idx got slot %0d idx %0d exp slot %0d idx %0d",
                           slot, idx_out, e[3:2], e[1:0]);
               end
            end
         end
         if (done) done_cnt++;
      end
      checks++;
      if (done_cnt != 1 || draws.size() != 1) begin
         errors++; $display("FAIL error_resume got done %0d draws %0d exp 1 1", done_cnt, draws.size());
      end
      while (draws.size() > 0) begin
         w = draws.pop_front(); checks++;
         if (w !== lfsr_m) begin errors++; $display("FAIL error_resume_word got %h exp %h", w, lfsr_m); end
         lfsr_m = lfsr_step(lfsr_m);
      end
   endtask

   task automatic test_stall();
      int emitted = 0, done_cnt = 0, stall_left = 5;
      logic [3:0] e;
      logic [15:0] w;
      reject_left = 0; perm_plan = 8'h6C; idx_ack = 1'b1;
      start = 1'b1; cycle(); start = 1'b0;
      for (int n = 0; n < 40; n++) begin
         cycle();
         if (stall_left > 0 && stall_left < 5 && !idx_valid) begin
            checks++; errors++;
            $display("FAIL stall_valid got %b exp 1", idx_valid);
         end
         if (idx_valid && slot == 2'd1 && stall_left > 0) begin
            idx_ack = 1'b0; stall_left--;
            gen_perm = 8'($urandom);
            checks++;
            if (exp_q.size() == 0 || {slot, idx_out} !== exp_q[0]) begin
               errors++; $display("FAIL stall_hold got slot %0d idx %0d exp slot 1 idx %0d",
                                  slot, idx_out, perm_plan[5:4]);
            end
         end else if (idx_valid) begin
            idx_ack = 1'b1; emitted++; checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL stall_idx unexpected slot %0d idx %0d", slot, idx_out);
            end else begin
               e = exp_q.pop_front();
               if ({slot, idx_out} !== e) begin
                  errors++;
                  $display("FAIL stall_idx got slot %0d idx %0d exp slot %0d idx %0d",
                           slot, idx_out, e[3:2], e[1:0]);
               end
            end
         end
         if (done) done_cnt++;
      end
      checks++;
      if (stall_left != 0 || emitted != 4 || done_cnt != 1) begin
         errors++; $display("FAIL stall_summary got stall %0d emit %0d done %0d exp 0 4 1",
                            stall_left, emitted, done_cnt);
      end
      while (draws.size() > 0) begin
         w = draws.pop_front(); checks++;
         if (w !== lfsr_m) begin errors++; $display("FAIL stall_word got %h exp %h", w, lfsr_m); end
         lfsr_m = lfsr_step(lfsr_m);
      end
   endtask

   task automatic test_abort();
      int done_cnt = 0;
      logic found = 1'b0;
      logic [3:0] e;
      logic [15:0] w;
      reject_left = 0; perm_plan = 8'h1B; idx_ack = 1'b1;
      start = 1'b1; cycle(); start = 1'b0;
      for (int n = 0; n < 30; n++) begin
         cycle();
         if (idx_valid && slot == 2'd2) begin
            abort = 1'b1; found = 1'b1;
            break;
         end
         if (idx_valid) e = exp_q.pop_front();
      end
      checks++;
      if (!found) begin errors++; $display("FAIL abort_reach got slot %0d exp 2", slot); end
      cycle(); abort = 1'b0;
      checks++;
      if ({idx_valid, busy, done, erro} !== 4'b0000) begin
         errors++; $display("FAIL abort_idle got v %b b %b d %b e %b exp 0000", idx_valid, busy, done, erro);
      end
      repeat (5) begin
         cycle();
         if (done) done_cnt++;
      end
      checks++;
      if (done_cnt != 0) begin errors++; $display("FAIL abort_done got %0d exp 0", done_cnt); end
      exp_q.delete();
      while (draws.size() > 0) begin
         w = draws.pop_front(); checks++;
         if (w !== lfsr_m) begin errors++; $display("FAIL abort_word got %h exp %h", w, lfsr_m); end
         lfsr_m = lfsr_step(lfsr_m);
      end
      perm_plan = 8'hE4;
      start = 1'b1; cycle(); start = 1'b0;
      for (int n = 0; n < 30; n++) begin
         cycle();
         if (idx_valid) begin
            checks++;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hx;
            if ({slot, idx_out} !== e) begin
               errors++; $display("FAIL abort_next_idx got slot %0d idx %0d exp %h", slot, idx_out, e);
            end
         end
         if (done) done_cnt++;
      end
      checks++;
      if (done_cnt != 1 || draws.size() != 1) begin
         errors++; $display("FAIL abort_next got done %0d draws %0d exp 1 1", done_cnt, draws.size());
      end
      while (draws.size() > 0) begin
         w = draws.pop_front(); checks++;
         if (w !== lfsr_m) begin errors++; $display("FAIL abort_next_word got %h exp %h", w, lfsr_m); end
         lfsr_m = lfsr_step(lfsr_m);
      end
   endtask

   task automatic test_async_reset();
      int done_cnt = 0;
      logic found = 1'b0;
      logic [3:0] e;
      logic [15:0] w;
      reject_left = 1; perm_plan = 8'hE4; idx_ack = 1'b0;
      start = 1'b1; cycle(); start = 1'b0;
      for (int n = 0; n < 30; n++) begin
         cycle();
         if (idx_valid) begin found = 1'b1; break; end
      end
      checks++;
      if (!found || idx_out !== 2'd3 || tentativas !== 4'd1) begin
         errors++; $display("FAIL areset_setup got valid %b idx %0d t %0d exp 1 3 1", idx_valid, idx_out, tentativas);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if (gen_entrada !== 16'h0000) begin
         errors++; $display("FAIL areset_gen_entrada got %h exp 0000", gen_entrada);
      end
      checks++;
      if ({idx_out, slot, idx_valid, busy, done, erro, tentativas} !== 14'h0) begin
         errors++;
         $display("FAIL areset_outputs got idx %0d slot %0d v %b b %b d %b e %b t %0d exp all 0",
                  idx_out, slot, idx_valid, busy, done, erro, tentativas);
      end
      @(posedge clock); #1;
      reset = 1'b0; gen_ready = 1'b0; last_word = 16'h0000;
      lfsr_m = 16'hACE1; draws.delete(); exp_q.delete();
      reject_left = 0; perm_plan = 8'h1B; idx_ack = 1'b1;
      start = 1'b1; cycle(); start = 1'b0;
      for (int n = 0; n < 30; n++) begin
         cycle();
         if (idx_valid) begin
            checks++;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hx;
            if ({slot, idx_out} !== e) begin
               errors++; $display("FAIL areset_next_idx got slot %0d idx %0d exp %h", slot, idx_out, e);
            end
         end
         if (done) done_cnt++;
      end
      checks++;
      if (done_cnt != 1 || draws.size() != 1) begin
         errors++; $display("FAIL areset_next got done %0d draws %0d exp 1 1", done_cnt, draws.size());
      end else begin
         w = draws.pop_front();
         if (w !== 16'hACE1) begin errors++; $display("FAIL areset_first_word got %h exp ace1", w); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_retry();
      test_error();
      test_stall();
      test_abort();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got running exp finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/controlador_permutacao.md
CONTROLADOR_PERMUTACAO -- requirements
Module: controlador_permutacao

Interface
REQ-001 Parameter: MAX_TENT, default 8, maximum number of random draws per request before declaring an error; legal range 1..15.
REQ-002 Parameter: SEMENTE, default 16'hACE1, LFSR reset value; shall be nonzero.
REQ-003 clock  input  1  system clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clock is clock.
REQ-005 start  input  1  request for one new permutation, sampled in IDLE or ERRO.
REQ-006 abort  input  1  cancels any request in progress.
REQ-007 gen_perm  input  8  permutation from the index generator; slot0=[7:6], slot1=[5:4], slot2=[3:2], slot3=[1:0].
REQ-008 gen_ready  input  1  generator valid flag, registered one cycle after gen_entrada.
REQ-009 idx_ack  input  1  consumer accepts the current idx_out.
REQ-010 gen_entrada  output  16  registered random word driven to the generator.
REQ-011 idx_out  output  2  current permutation index.
REQ-012 idx_valid  output  1  idx_out is valid.
REQ-013 slot  output  2  position (0..3) of idx_out within the permutation.
REQ-014 busy  output  1  high in every state except IDLE and ERRO.
REQ-015 done  output  1  one-cycle pulse after the fourth index is accepted.
REQ-016 erro  output  1  MAX_TENT consecutive draws were rejected.
REQ-017 tentativas  output  4  number of rejected draws in the current request.

Function
REQ-018 The block shall hold a 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1: next = {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
REQ-019 The LFSR shall advance only in SORTEIA and shall otherwise hold its value.
REQ-020 The FSM states shall be IDLE, SORTEIA, ESPERA, AVALIA, EMITE, FIM and ERRO.
REQ-021 IDLE: start=1 shall go to SORTEIA and clear tentativas; otherwise the FSM shall remain in IDLE.
REQ-022 SORTEIA: gen_entrada shall load the current LFSR value, the LFSR shall advance, and the FSM shall go to ESPERA.
REQ-023 ESPERA: the FSM shall wait exactly one cycle for the generator's register latency, then go to AVALIA.
REQ-024 AVALIA, gen_ready=1: the block shall latch gen_perm, set slot=0 and go to EMITE.
REQ-025 AVALIA, gen_ready=0: tentativas shall increment; the FSM shall go to ERRO if the new value equals MAX_TENT, otherwise to SORTEIA.
REQ-026 EMITE: idx_valid=1, and idx_out shall equal the latched field selected by slot.
REQ-027 EMITE with idx_ack=1 and slot<3: slot shall increment; with idx_ack=1 and slot=3: go to FIM.
REQ-028 EMITE with idx_ack=0: idx_out, slot and idx_valid shall hold with no timeout.
REQ-029 idx_valid shall be 0 in every state except EMITE.
REQ-030 Minimum request latency shall be start to first idx_valid = 4 cycles (IDLE→SORTEIA→ESPERA→AVALIA→EMITE).
REQ-031 FIM: done=1 for exactly one cycle, then go to IDLE; a start in FIM shall be ignored.
REQ-032 ERRO: erro=1 and tentativas shall hold; start=1 shall clear erro and tentativas and go to SORTEIA.
REQ-033 abort=1 in any state other than IDLE shall go to IDLE next cycle, with no done pulse, erro cleared and the LFSR unchanged.
REQ-034 abort shall have priority over start, idx_ack and gen_ready in the same cycle.
REQ-035 Changes on gen_perm outside AVALIA shall not affect idx_out.
REQ-036 tentativas shall saturate at MAX_TENT and never wrap.

Reset
REQ-037 On reset the block shall enter IDLE immediately (asynchronous), including mid-request.
REQ-038 On reset: LFSR=SEMENTE, gen_entrada=16'h0000, idx_out=0, slot=0, idx_valid=0, busy=0, done=0, erro=0, tentativas=0, latched permutation=8'h00.
REQ-039 After reset is released, the first gen_entrada load shall be 16'hACE1 (default SEMENTE).

Verification
REQ-040 Reset, start pulse, gen_ready=1 with gen_perm=8'h1B in AVALIA, idx_ack held high → gen_entrada=16'hACE1; idx_out 0,1,2,3 on consecutive cycles with slot 0..3; done pulse one cycle later; tentativas=0.
REQ-041 gen_ready=0 on two draws, then 1 with gen_perm=8'hE4 → tentativas=2; three distinct gen_entrada values; indices 3,2,1,0 emitted.
REQ-042 MAX_TENT=8, gen_ready tied low → erro=1 and tentativas=8 after the 8th AVALIA; busy=0, idx_valid=0; a later start clears erro and resumes drawing.
REQ-043 idx_ack low for 5 cycles during slot 1 → idx_out and slot stable, idx_valid high throughout; emission resumes on ack, and done still fires once.
REQ-044 abort asserted in EMITE at slot 2 together with idx_ack → IDLE next cycle, no done, idx_valid=0; the next request draws the following LFSR value.
REQ-045 reset asserted mid-EMITE between clock edges → all outputs at REQ-038 values before the next edge.
